// File: rtl/tft_bus_arb_if.sv
// tft_bus_arb_if: requester and transmitter signal bundle for the TFT bus arbiter
interface tft_bus_arb_if #(parameter int NUM_REQ = 3);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] req_transmit;
  logic [NUM_REQ-1:0] req_dc;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] req_busy;
  logic tft_busy;
  logic tft_transmit;
  logic tft_dc;
  logic [7:0] tft_data;
  logic timeout_event;
  modport master (
    output req, req_transmit, req_dc, req_data, tft_busy,
    input grant, req_busy, tft_transmit, tft_dc, tft_data, timeout_event
  );
  modport slave (
    input req, req_transmit, req_dc, req_data, tft_busy,
    output grant, req_busy, tft_transmit, tft_dc, tft_data, timeout_event
  );
endinterface

// File: rtl/tft_bus_arb.sv
// tft_bus_arb: per-transaction round-robin owner of the shared TFT byte transmitter
module tft_bus_arb #(
  parameter int NUM_REQ = 3,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input logic clk,
  input logic global_reset,
  tft_bus_arb_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, OWN, DRAIN} state_t;
  state_t state, state_n;
  logic [IW-1:0] rr_last, rr_n, win;
  logic [NUM_REQ-1:0] grant_n, mask, mask_set, cand;
  logic [15:0] cnt, cnt_n;
  logic found, accept, idle, fire, ev_n;
  // rr_last doubles as the owner index while in OWN
  assign bus.req_busy = ~bus.grant | {NUM_REQ{bus.tft_busy | bus.tft_transmit}};
  assign cand = bus.req & ~mask;
  assign accept = (state == OWN) && bus.req_transmit[rr_last] && !bus.req_busy[rr_last];
  assign idle = (state == OWN) && !accept && !bus.tft_busy;
  assign fire = (TIMEOUT != 16'd0) && idle && (cnt == TIMEOUT - 16'd1);
  // first unmasked requester after the last winner, wrapping at NUM_REQ
  always_comb begin
    found = 1'b0;
    win = rr_last;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && cand[IW'((int'(rr_last) + k) % NUM_REQ)]) begin
        found = 1'b1;
        win = IW'((int'(rr_last) + k) % NUM_REQ);
      end
    end
  end
  // ownership FSM: next state, grant, watchdog count and revoke request
  always_comb begin
    state_n = state;
    grant_n = bus.grant;
    rr_n = rr_last;
    cnt_n = '0;
    ev_n = 1'b0;
    mask_set = '0;
    case (state)
      IDLE: if (found) begin
        state_n = OWN;
        grant_n = '0;
        grant_n[win] = 1'b1;
        rr_n = win;
      end
      OWN: begin
        cnt_n = accept ? 16'd0 : idle ? cnt + 16'd1 : cnt;
        if (!bus.req[rr_last]) begin
          state_n = DRAIN;
          grant_n = '0;
          cnt_n = '0;
        end else if (fire) begin
          state_n = DRAIN;
          grant_n = '0;
          cnt_n = '0;
          ev_n = 1'b1;
          mask_set[rr_last] = 1'b1;
        end
      end
      DRAIN: if (!bus.tft_busy && !bus.tft_transmit) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // arbitration state; a revoked requester stays masked until it drops req
  always_ff @(posedge clk or posedge global_reset) begin
    if (global_reset) begin
      state <= IDLE;
      bus.grant <= '0;
      rr_last <= IW'(NUM_REQ - 1);
      cnt <= '0;
      mask <= '0;
      bus.timeout_event <= 1'b0;
    end else begin
      state <= state_n;
      bus.grant <= grant_n;
      rr_last <= rr_n;
      cnt <= cnt_n;
      mask <= (mask & bus.req) | mask_set;
      bus.timeout_event <= ev_n;
    end
  end
  // forward the owner's accepted strobe; dc/data hold until the next one
  always_ff @(posedge clk or posedge global_reset) begin
    if (global_reset) begin
      bus.tft_transmit <= 1'b0;
      bus.tft_dc <= 1'b0;
      bus.tft_data <= 8'h00;
    end else begin
      bus.tft_transmit <= accept;
      if (accept) begin
        bus.tft_dc <= bus.req_dc[rr_last];
        bus.tft_data <= bus.req_data[{rr_last, 3'b000} +: 8];
      end
    end
  end
endmodule

// File: tb/tb_tft_bus_arb.sv
// tb_tft_bus_arb: directed checks of ownership, round-robin, forwarding, watchdog and reset
module tb_tft_bus_arb;
  logic clk = 1'b0;
  logic global_reset = 1'b1;
  int checks = 0;
  int fails = 0;
  int overlap = 0;
  int rise_busy = 0;
  int multi = 0;
  int busy_cnt = 0;
  logic [2:0] prev_grant = '0;
  tft_bus_arb_if #(.NUM_REQ(3)) bus();
  tft_bus_arb #(.NUM_REQ(3), .TIMEOUT(16'd8)) dut (.clk(clk), .global_reset(global_reset), .bus(bus));
  always #5 clk = ~clk;
  // transmitter model: busy from the cycle after the strobe, for 4 cycles
  always @(posedge clk) busy_cnt <= bus.tft_transmit ? 4 : (busy_cnt != 0 ? busy_cnt - 1 : 0);
  assign bus.tft_busy = busy_cnt != 0;
  // invariants watched over the whole run
  always @(negedge clk) begin
    if (bus.tft_transmit && bus.tft_busy) overlap <= overlap + 1;
    if (!global_reset && bus.tft_busy && |(bus.grant & ~prev_grant)) rise_busy <= rise_busy + 1;
    if (!$onehot0(bus.grant)) multi <= multi + 1;
    prev_grant <= bus.grant;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input int i, input logic dc, input logic [7:0] d, input string tag);
    int n = 0;
    while (bus.req_busy[i] && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_ready"}, 32'(bus.req_busy[i]), 0);
    bus.req_transmit[i] = 1'b1;
    bus.req_dc[i] = dc;
    bus.req_data[8*i +: 8] = d;
    tick();
    bus.req_transmit = '0;
    chk({tag, "_tx"}, 32'(bus.tft_transmit), 1);
    chk({tag, "_dc"}, 32'(bus.tft_dc), 32'(dc));
    chk({tag, "_data"}, 32'(bus.tft_data), 32'(d));
  endtask
  task automatic wait_grant(input string tag, input logic [2:0] exp);
    int n = 0;
    while (bus.grant == 3'b000 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 32'(bus.grant), 32'(exp));
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((bus.tft_busy || bus.tft_transmit) && n < 30) begin
      tick();
      n++;
    end
    tick();
    tick();
  endtask
  task automatic do_reset();
    global_reset = 1'b1;
    tick();
    global_reset = 1'b0;
    tick();
  endtask
  logic [2:0] rr_exp [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  int rr_own [4] = '{0, 1, 2, 0};
  initial begin
    bus.req = '0;
    bus.req_transmit = '0;
    bus.req_dc = '0;
    bus.req_data = '0;
    #3;
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_tx", 32'(bus.tft_transmit), 0);
    chk("rst_dc", 32'(bus.tft_dc), 0);
    chk("rst_data", 32'(bus.tft_data), 0);
    chk("rst_ev", 32'(bus.timeout_event), 0);
    tick();
    global_reset = 1'b0;
    tick();
    // single owner, three bytes
    bus.req = 3'b001;
    tick();
    chk("s1_grant", 32'(bus.grant), 32'h1);
    send(0, 1'b0, 8'h2a, "s1_b0");
    tick();
    chk("s1_pulse", 32'(bus.tft_transmit), 0);
    chk("s1_hold", 32'(bus.tft_data), 32'h2a);
    send(0, 1'b1, 8'h00, "s1_b1");
    send(0, 1'b1, 8'h30, "s1_b2");
    bus.req = '0;
    wait_idle();
    chk("s1_release", 32'(bus.grant), 0);
    // round-robin from a fresh pointer
    do_reset();
    bus.req = 3'b111;
    for (int s = 0; s < 4; s++) begin
      wait_grant($sformatf("rr_grant%0d", s), rr_exp[s]);
      if (s < 3) begin
        int n = 0;
        send(rr_own[s], 1'b1, 8'(8'h10 + rr_own[s]), $sformatf("rr_b%0d", s));
        while (bus.req_busy[rr_own[s]] && n < 20) begin
          tick();
          n++;
        end
        bus.req[rr_own[s]] = 1'b0;
        tick();
        chk($sformatf("rr_drop%0d", s), 32'(bus.grant), 0);
        bus.req[rr_own[s]] = 1'b1;
      end
    end
    // non-owner strobe is dropped
    bus.req_transmit[2] = 1'b1;
    bus.req_data[23:16] = 8'haa;
    chk("no_busy_before", 32'(bus.req_busy[2]), 1);
    tick();
    bus.req_transmit = '0;
    chk("no_tx", 32'(bus.tft_transmit), 0);
    chk("no_data", 32'(bus.tft_data), 32'h12);
    chk("no_busy_after", 32'(bus.req_busy[2]), 1);
    // owner drops while its byte is in flight
    send(0, 1'b0, 8'h44, "dd_b");
    tick();
    chk("dd_busy", 32'(bus.tft_busy), 1);
    bus.req = 3'b010;
    tick();
    begin
      int n = 0;
      while (bus.tft_busy && n < 20) begin
        chk("dd_hold", 32'(bus.grant), 0);
        tick();
        n++;
      end
    end
    chk("dd_s0", 32'(bus.grant), 0);
    tick();
    chk("dd_s1", 32'(bus.grant), 0);
    tick();
    chk("dd_s2", 32'(bus.grant), 32'h2);
    bus.req = '0;
    wait_idle();
    // watchdog revoke after 8 idle owner cycles
    bus.req = 3'b001;
    tick();
    chk("wd_grant", 32'(bus.grant), 32'h1);
    repeat (7) tick();
    chk("wd_early_ev", 32'(bus.timeout_event), 0);
    chk("wd_early_grant", 32'(bus.grant), 32'h1);
    tick();
    chk("wd_ev", 32'(bus.timeout_event), 1);
    chk("wd_revoked", 32'(bus.grant), 0);
    tick();
    chk("wd_pulse", 32'(bus.timeout_event), 0);
    repeat (5) tick();
    chk("wd_masked", 32'(bus.grant), 0);
    bus.req = '0;
    tick();
    bus.req = 3'b001;
    wait_grant("wd_regrant", 3'b001);
    // async reset between edges while a strobe is out
    send(0, 1'b1, 8'h5a, "ar_b");
    #2 global_reset = 1'b1;
    #1;
    chk("ar_grant", 32'(bus.grant), 0);
    chk("ar_tx", 32'(bus.tft_transmit), 0);
    chk("ar_ev", 32'(bus.timeout_event), 0);
    bus.req = '0;
    tick();
    global_reset = 1'b0;
    wait_idle();
    bus.req = 3'b011;
    wait_grant("ar_first", 3'b001);
    bus.req = '0;
    wait_idle();
    chk("inv_overlap", 32'(overlap), 0);
    chk("inv_grant_busy", 32'(rise_busy), 0);
    chk("inv_onehot", 32'(multi), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/tft_bus_arb.md
Name: tft_bus_arb

Overview:
- Shares the single byte-level TFT transmitter (tft_dc / tft_data / tft_transmit / tft_busy) among NUM_REQ requesters, e.g. the init sequencer, the maze renderer and the status overlay.
- Grants ownership per transaction: once granted, a requester keeps the bus for a whole command+data burst until it drops its request.
- Round-robin arbitration between transactions.
- An optional watchdog revokes a stalled owner.

Parameters:
- NUM_REQ, 3: number of requesters (2..8).
- TIMEOUT, 16'd50000: idle-owner revoke limit in clk cycles; 0 disables the watchdog.

Ports:
- clk  in  1  system clock.
- global_reset  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester bus request; held high for the whole transaction.
- req_transmit  in  NUM_REQ  one-cycle byte strobe per requester.
- req_dc  in  NUM_REQ  D/C bit per requester.
- req_data  in  8*NUM_REQ  byte per requester; requester i uses [8i+7:8i].
- grant  out  NUM_REQ  one-hot ownership, registered.
- req_busy  out  NUM_REQ  per-requester busy (combinational from registered state and tft_busy).
- tft_busy  in  1  transmitter busy; rises the cycle after tft_transmit and stays high until the byte is shifted out.
- tft_transmit  out  1  one-cycle strobe to the transmitter.
- tft_dc  out  1  D/C to the transmitter.
- tft_data  out  8  byte to the transmitter.
- timeout_event  out  1  one-cycle pulse when an owner is revoked.

Behaviour:
- Reset (async, any state, mid-byte included):
  - grant=0, tft_transmit=0, tft_dc=0, tft_data=0, timeout_event=0.
  - state=IDLE, rr_last=NUM_REQ-1 (requester 0 wins first), timeout counter=0, revoke mask=0.
  - A byte already inside the transmitter is not aborted by this block.
- req_busy[i] = ~grant[i] | tft_busy | tft_transmit. Requesters strobe only when their req_busy is low.
- Strobe forwarding:
  - In OWN, req_transmit[owner] with req_busy[owner]=0 is registered into tft_transmit/tft_dc/tft_data.
  - Latency is 1 cycle; tft_transmit is high for exactly 1 cycle.
  - tft_dc/tft_data hold their last value until the next strobe.
- Strobes are dropped silently from a non-owner, and from the owner while req_busy is high.
- States:
  - IDLE: if any unmasked req is high, pick the first one scanning from rr_last+1 with wrap at NUM_REQ. Set its grant bit next cycle, rr_last=winner, go to OWN. Request-to-grant latency is 1 cycle.
  - OWN:
    - Owner req low -> DRAIN; grant drops the same edge.
    - Watchdog fires -> DRAIN; grant drops, timeout_event pulses, owner bit set in revoke mask.
  - DRAIN: wait until tft_busy=0 and tft_transmit=0, then -> IDLE. The next grant therefore appears no earlier than 2 cycles after the transmitter goes idle.
- Watchdog:
  - The 16-bit counter increments each OWN cycle with no accepted strobe and tft_busy=0.
  - It clears on an accepted strobe or on leaving OWN.
  - It fires when count == TIMEOUT-1; it never fires when TIMEOUT=0.
- Revoke mask: bit i clears when req[i] is low. A revoked requester must deassert req and re-request.
- Simultaneous events:
  - The owner drops req in the same cycle it strobes: the byte is still forwarded, then DRAIN.
  - The owner strobes on the cycle the watchdog would fire: the strobe wins and the counter clears.
- Only one grant bit is ever high; grant is 0 in IDLE and DRAIN.

Test Plan:
- Single owner: after reset, req=3'b001, then 3 strobes (COMM 0x2a, DATA 0x00, DATA 0x30) each sent when req_busy[0]=0.
  - Required: grant=001 one cycle after req.
  - Required: tft_transmit 1 cycle after each strobe, with dc/data 0/2a, 1/00, 1/30.
  - Required: no strobe from this block while tft_busy=1.
- Round-robin: req=3'b111 held, each owner sends 1 byte then drops and re-raises req.
  - Required: grant order 001, 010, 100, 001.
  - Required: grant never changes while tft_busy=1.
- Non-owner drop: owner 0 granted, requester 2 strobes 0xAA.
  - Required: no tft_transmit; tft_data unchanged; req_busy[2]=1 throughout.
- Drop during byte: owner drops req with tft_busy=1 and req[1] high.
  - Required: grant=000 until tft_busy falls.
  - Required: grant=010 exactly 2 cycles later.
- Watchdog: TIMEOUT=8, owner 0 holds req with no strobes.
  - Required: timeout_event pulses after 8 idle cycles, and grant=000.
  - Required: requester 0 is not regranted until req[0] drops and re-rises.
- Async reset: assert global_reset mid-transaction, between clock edges.
  - Required: grant=0, tft_transmit=0, timeout_event=0 immediately.
  - Required: after release, req=3'b011 gives grant=001 first.
